// File: rtl/digit_demux_loader.sv
// ============================================================================
// digit_demux_loader
// ----------------------------------------------------------------------------
// Write port for the 7-segment digit bank. A valid/ready stream of DATA_W-bit
// nibbles is written in order into DIGITS digit slots. Slot 0 is written
// first. A frame ends after DIGITS beats, or earlier on a beat that carries
// i_wr_last. The end of a frame gives a one-cycle COMMIT state, in which
// o_frame_done is high and o_wr_ready is low.
//
// Optional feature macro: DIGIT_SHADOW_EN
//   defined   : beats go to a shadow bank. The visible bank (o_dig_flat) is
//               copied from the shadow bank in one step during COMMIT.
//   undefined : beats write the visible bank directly.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          asynchronous, active-high reset
//   i_wr_data      nibble to store
//   i_wr_valid     i_wr_data is valid
//   i_wr_last      final beat of the frame (sampled on accepted beats only)
//   o_wr_ready     loader can accept a beat this cycle
//   i_clear        synchronous clear of all storage and the pointer
//   o_dig_flat     digit i at [i*DATA_W +: DATA_W]
//   o_wr_ptr       index of the next slot to be written
//   o_frame_done   one-cycle pulse on frame completion
// ============================================================================
module digit_demux_loader #(
    parameter int DATA_W = 4,
    parameter int DIGITS = 8,
    localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_wr_valid,
    input  logic                     i_wr_last,
    output logic                     o_wr_ready,
    input  logic                     i_clear,
    output logic [DIGITS*DATA_W-1:0] o_dig_flat,
    output logic [PTR_W-1:0]         o_wr_ptr,
    output logic                     o_frame_done
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic              r_alive;
    logic              w_ready;
    logic              w_accept;
    logic              w_frame_end;
    logic              w_done;

    // r_alive holds o_wr_ready low until the first edge after reset release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_alive <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        w_accept    = 1'b0;
        w_frame_end = 1'b0;

        case (r_state)
            S_IDLE, S_FILL: w_ready = r_alive && !i_clear;
            // A clear that arrives in the COMMIT cycle cancels the pulse.
            S_COMMIT:       w_done  = !i_clear;
            default:        ;
        endcase

        w_accept    = i_wr_valid && w_ready;
        w_frame_end = w_accept && (i_wr_last || (r_ptr == LAST_PTR));

        if (i_clear) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE, S_FILL: begin
                    if (w_frame_end) begin
                        // The pointer goes back to 0 on the final beat so it
                        // never reaches DIGITS.
                        w_state_nxt = S_COMMIT;
                        w_ptr_nxt   = '0;
                    end else if (w_accept) begin
                        w_state_nxt = S_FILL;
                        w_ptr_nxt   = r_ptr + 1'b1;
                    end
                end
                S_COMMIT: begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = '0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = '0;
                end
            endcase
        end
    end

    // Digit storage
    logic [DATA_W-1:0] r_vis [DIGITS];

`ifdef DIGIT_SHADOW_EN
    logic [DATA_W-1:0] r_shadow [DIGITS];

    // Slots not written in this frame keep their old shadow value, so that
    // value goes into the copy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_shadow[i] <= '0;
                r_vis[i]    <= '0;
            end
        end else if (i_clear) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_shadow[i] <= '0;
                r_vis[i]    <= '0;
            end
        end else begin
            if (w_accept) begin
                r_shadow[r_ptr] <= i_wr_data;
            end
            if (r_state == S_COMMIT) begin
                for (int i = 0; i < DIGITS; i++) begin
                    r_vis[i] <= r_shadow[i];
                end
            end
        end
    end
`else
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_vis[i] <= '0;
            end
        end else if (i_clear) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_vis[i] <= '0;
            end
        end else if (w_accept) begin
            r_vis[r_ptr] <= i_wr_data;
        end
    end
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_flat
        assign o_dig_flat[g*DATA_W +: DATA_W] = r_vis[g];
    end

    assign o_wr_ready   = w_ready;
    assign o_wr_ptr     = r_ptr;
    assign o_frame_done = w_done;

endmodule

// File: doc/digit_demux_loader.md
# digit_demux_loader

Display-side write port for the 7-segment digit bank: the inverse of the digit select mux. It accepts a valid/ready stream of 4-bit nibbles, e.g. hex digits decoded from received UART bytes, and scatters them in order into eight digit registers. The flattened digit bus feeds the scan mux directly. A frame is eight nibbles, or fewer when terminated early with `wr_last`; completion is flagged with a one-cycle pulse.

## Interface
- `DATA_W`, default 4: bits per digit.
- `DIGITS`, default 8: number of digit slots. `PTR_W = $clog2(DIGITS)`.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_data`  in  DATA_W  nibble to store.
- `wr_valid`  in  1  `wr_data` is valid.
- `wr_last`  in  1  qualifies the current beat as the final one of the frame; sampled only on an accepted beat.
- `wr_ready`  out  1  loader can accept a beat this cycle.
- `clear`  in  1  synchronous clear request, one cycle.
- `dig_flat`  out  DIGITS*DATA_W  digit i is at `[i*DATA_W +: DATA_W]`; digit 0 is written first.
- `wr_ptr`  out  PTR_W  index of the next slot to be written.
- `frame_done`  out  1  one-cycle pulse on frame completion.

## Operation
- A beat is accepted on a clock edge where `wr_valid && wr_ready`. The nibble is written to slot `wr_ptr`, and `wr_ptr` then increments.
- The FSM has three states:
  - **IDLE**: `wr_ptr` = 0, `wr_ready` = 1.
  - **FILL**: at least one beat has been accepted, `wr_ready` = 1.
  - **COMMIT**: lasts one cycle, `wr_ready` = 0, `frame_done` = 1.
- FSM transitions:
  - IDLE→FILL on an accepted beat that does not end the frame.
  - IDLE/FILL→COMMIT on an accepted beat with `wr_last` = 1, or on an accepted beat while `wr_ptr` = DIGITS-1.
  - COMMIT→IDLE unconditionally, with `wr_ptr` returned to 0.
- **Wrap-around**: the pointer never exceeds DIGITS-1. The ninth beat of a stream always starts a new frame at slot 0.
- **Partial frame**: slots not written since the last commit keep their previous values.
- **clear**:
  - Zeroes all digit storage (shadow and visible), sets `wr_ptr` to 0 and the state to IDLE.
  - `wr_ready` is forced to 0 combinationally while `clear` = 1, so no beat is accepted in that cycle.
  - `clear` has priority over COMMIT. `frame_done` is suppressed if `clear` arrives in the COMMIT cycle.
- **Reset**: `dig_flat` = 0, `wr_ptr` = 0, `frame_done` = 0, state IDLE. `wr_ready` = 1 from the first edge after reset is released; it reads 0 while `rst` is high. Reset mid-frame discards all partial data.
- Data is held unchanged while `wr_valid` = 0. Back-to-back beats are accepted at one per cycle, except during the COMMIT bubble.

## Timing
- Accepted beat at edge N: `wr_ptr` is updated after N.
- Direct mode (macro absent): the slot is visible on `dig_flat` after edge N.
- Frame-ending beat at edge N: COMMIT and `frame_done` = 1 during cycle N+1. `wr_ready` = 0 during N+1. The next beat is accepted no earlier than edge N+2.
- Shadow mode (macro defined): `dig_flat` updates all slots atomically at the edge ending cycle N+1, and is visible from N+2.
- Throughput: DIGITS beats per DIGITS+1 cycles for full frames.
- `frame_done` is never high for more than one cycle and never high while `wr_ready` = 1.

## Configuration
- `DIGIT_SHADOW_EN`
  - **Defined**: writes go to a shadow register bank. `dig_flat` is driven from a separate visible bank, copied from the shadow only on COMMIT. The display never shows a partially written frame. Unwritten shadow slots carry their old values into the copy.
  - **Undefined**: there is no shadow bank. Each accepted beat writes the visible slot directly, with one-cycle latency. COMMIT still occurs, for `frame_done` and the ready bubble.
- Port list and FSM are identical in both builds.

## Test plan
- **Full frame, direct mode**: after reset, send 1,2,3,4,5,6,7,8 back-to-back. Required: `dig_flat` = 0x87654321; `frame_done` pulses once, one cycle after beat 8; `wr_ready` = 0 for exactly that cycle; `wr_ptr` returns to 0.
- **Shadow atomicity** (`DIGIT_SHADOW_EN`): preload 0x87654321, then send A,B,C. `dig_flat` stays 0x87654321 during the beats. Send D with `wr_last`. `dig_flat` becomes 0x8765DCBA two cycles after the D beat.
- **Wrap**: send 9 beats 0..8 continuously with `valid` held high. Required: the ninth beat (8) lands in slot 0 after the commit bubble; `wr_ptr` = 1 afterward.
- **Clear collision**: assert `clear` with `wr_valid` = 1 and `wr_data` = F at `wr_ptr` = 3. Required: `wr_ready` = 0 that cycle, the beat is not accepted, `dig_flat` = 0, `wr_ptr` = 0, no `frame_done`.
- **Async reset mid-frame**: after 5 beats, pulse `rst` between clock edges. Required: `dig_flat` = 0 and `wr_ptr` = 0 immediately, with no edge needed. The next 8 beats form a clean frame.
- **Stalls**: toggle `wr_valid` randomly during a 0xFEDCBA98 frame. Required: identical final `dig_flat`, and exactly one `frame_done`.
